// File: rtl/operand_fetch_ctrl.sv
// Operand fetch sequencer: reads both ALU source operands through one shared
// register-file read port, bypasses same-cycle writes, and hands off via valid/ready.
module operand_fetch_ctrl #(
    parameter int unsigned DW = 8,
    parameter int unsigned SW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [SW-1:0] src1sel,
    input  logic [SW-1:0] src2sel,
    output logic [SW-1:0] portsel,
    input  logic [DW-1:0] portdata,
    input  logic          wren,
    input  logic [4:0]    wrsel,
    input  logic [DW-1:0] wrdata,
    output logic [DW-1:0] op1,
    output logic [DW-1:0] op2,
    output logic          op_valid,
    input  logic          op_ready
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH1,
        FETCH2,
        DONE
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [SW-1:0] sel1;
    logic [SW-1:0] sel2;
    logic          bypass;
    logic [DW-1:0] fetched;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        portsel    = '0;
        op_valid   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !rst;
                if (req_valid) next_state = FETCH1;
            end
            FETCH1: begin
                portsel    = sel1;
                next_state = (sel1 == sel2) ? DONE : FETCH2;
            end
            FETCH2: begin
                portsel    = sel2;
                next_state = DONE;
            end
            DONE: begin
                op_valid = 1'b1;
                if (op_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Only register selects (< 32) can be bypassed; constant selects never match.
    assign bypass  = wren && (portsel[SW-1:5] == '0) && (wrsel == portsel[4:0]);
    assign fetched = bypass ? wrdata : portdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            sel1 <= '0;
            sel2 <= '0;
            op1  <= '0;
            op2  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        sel1 <= src1sel;
                        sel2 <= src2sel;
                    end
                end
                FETCH1: begin
                    op1 <= fetched;
                    if (sel1 == sel2) op2 <= fetched;
                end
                FETCH2:  op2 <= fetched;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Directed self-checking bench for operand_fetch_ctrl; a regfile model drives
// the read-port mux and expected operand pairs flow through a scoreboard queue.
module tb_operand_fetch_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned SW = 6;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } pair_t;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [SW-1:0] src1sel;
    logic [SW-1:0] src2sel;
    logic [SW-1:0] portsel;
    logic [DW-1:0] portdata;
    logic          wren;
    logic [4:0]    wrsel;
    logic [DW-1:0] wrdata;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic          op_valid;
    logic          op_ready;

    logic [DW-1:0] rf [32];
    pair_t         sb [$];
    int            tests;
    int            failed;

    operand_fetch_ctrl #(.DW(DW), .SW(SW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .src1sel(src1sel), .src2sel(src2sel),
        .portsel(portsel), .portdata(portdata),
        .wren(wren), .wrsel(wrsel), .wrdata(wrdata),
        .op1(op1), .op2(op2), .op_valid(op_valid), .op_ready(op_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared operand mux: 0-31 registers, 32 constant one, 33-63 zero.
    always_comb begin
        portdata = '0;
        if (portsel < 6'd32)       portdata = rf[portsel[4:0]];
        else if (portsel == 6'd32) portdata = 8'h01;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ops(input string tag);
        pair_t e;
        if (sb.size() == 0) begin
            tests++;
            failed++;
            $error("FAIL %s: observed output with empty scoreboard expected queued pair", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_op1"}, 32'(op1), 32'(e.a));
            chk({tag, "_op2"}, 32'(op2), 32'(e.b));
        end
    endtask

    // Issue one request from IDLE and step to DONE, checking port sequence and latency.
    task automatic fetch(input string tag, input logic [SW-1:0] s1, input logic [SW-1:0] s2,
                         input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        pair_t p;
        req_valid = 1'b1;
        src1sel   = s1;
        src2sel   = s2;
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        p.a = e1;
        p.b = e2;
        sb.push_back(p);
        tick;
        req_valid = 1'b0;
        chk({tag, "_portsel1"}, 32'(portsel), 32'(s1));
        chk({tag, "_valid_early1"}, 32'(op_valid), 32'd0);
        if (s1 != s2) begin
            tick;
            chk({tag, "_portsel2"}, 32'(portsel), 32'(s2));
            chk({tag, "_valid_early2"}, 32'(op_valid), 32'd0);
        end
        tick;
        chk({tag, "_valid"}, 32'(op_valid), 32'd1);
        chk({tag, "_portsel_done"}, 32'(portsel), 32'd0);
        check_ops(tag);
    endtask

    task automatic complete(input string tag);
        op_ready = 1'b1;
        tick;
        op_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(op_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        pair_t p;
        tests     = 0;
        failed    = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        src1sel   = '0;
        src2sel   = '0;
        wren      = 1'b0;
        wrsel     = '0;
        wrdata    = '0;
        op_ready  = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 8'(i * 7 + 3);
        rf[3] = 8'h5A;
        rf[7] = 8'h11;
        rf[9] = 8'hC3;
        rf[4] = 8'h10;
        rf[5] = 8'h6E;
        rf[0] = 8'h22;

        tick;
        tick;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_op_valid", 32'(op_valid), 32'd0);
        chk("rst_op1", 32'(op1), 32'd0);
        chk("rst_op2", 32'(op2), 32'd0);
        chk("rst_portsel", 32'(portsel), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);

        fetch("basic", 6'd3, 6'd7, 8'h5A, 8'h11);
        complete("basic");

        fetch("equal", 6'd9, 6'd9, 8'hC3, 8'hC3);
        complete("equal");

        wren = 1'b1; wrsel = 5'd0; wrdata = 8'hFF;
        fetch("const", 6'd32, 6'd40, 8'h01, 8'h00);
        complete("const");
        wren = 1'b0;
        rf[0] = 8'hFF;

        // Bypass needs per-cycle write control, so it is stepped by hand.
        req_valid = 1'b1; src1sel = 6'd4; src2sel = 6'd5;
        chk("byp_req_ready", 32'(req_ready), 32'd1);
        p.a = 8'hAB; p.b = rf[5];
        sb.push_back(p);
        tick;
        req_valid = 1'b0;
        wren = 1'b1; wrsel = 5'd4; wrdata = 8'hAB;
        chk("byp_portsel1", 32'(portsel), 32'd4);
        tick;
        rf[4] = 8'hAB;
        wrsel = 5'd6; wrdata = 8'h99;
        chk("byp_portsel2", 32'(portsel), 32'd5);
        tick;
        wren = 1'b0;
        rf[6] = 8'h99;
        chk("byp_valid", 32'(op_valid), 32'd1);
        check_ops("byp");
        complete("byp");

        fetch("bp", 6'd3, 6'd7, 8'h5A, 8'h11);
        req_valid = 1'b1; src1sel = 6'd3; src2sel = 6'd3;
        wren = 1'b1; wrsel = 5'd3; wrdata = 8'h77;
        for (int i = 0; i < 5; i++) begin
            chk("bp_op1", 32'(op1), 32'h5A);
            chk("bp_op2", 32'(op2), 32'h11);
            chk("bp_valid", 32'(op_valid), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            tick;
            wren = 1'b0;
            rf[3] = 8'h77;
        end
        op_ready = 1'b1;
        tick;
        op_ready = 1'b0;
        chk("bp_done_valid", 32'(op_valid), 32'd0);
        chk("bp_done_ready", 32'(req_ready), 32'd1);
        p.a = 8'h77; p.b = 8'h77;
        sb.push_back(p);
        tick;
        req_valid = 1'b0;
        chk("bp_next_portsel", 32'(portsel), 32'd3);
        tick;
        chk("bp_next_valid", 32'(op_valid), 32'd1);
        check_ops("bp_next");
        complete("bp_next");

        req_valid = 1'b1; src1sel = 6'd1; src2sel = 6'd2;
        tick;
        req_valid = 1'b0;
        tick;
        chk("mid_in_fetch2", 32'(portsel), 32'd2);
        rst = 1'b1;
        tick;
        chk("mid_rst_valid", 32'(op_valid), 32'd0);
        chk("mid_rst_op1", 32'(op1), 32'd0);
        chk("mid_rst_op2", 32'(op2), 32'd0);
        chk("mid_rst_portsel", 32'(portsel), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mid_no_valid", 32'(op_valid), 32'd0);
            tick;
        end
        fetch("fresh", 6'd12, 6'd33, rf[12], 8'h00);
        complete("fresh");

        tests++;
        assert (sb.size() == 0) else begin
            failed++;
            $error("FAIL sb_empty: observed %0d left expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
